xilinx_dram_wr_arbiter: RTL and testbench
=========================================

# xilinx_dram_wr_arbiter

Round-robin write-port arbiter and read sequencer for a WIDTH-bit, 2^ABITS-deep distributed RAM built from per-bit `RAM64X1D` (ABITS=6) or `RAM128X1D` (ABITS=7) primitives. It shares the RAM's single write port between two valid/ready requesters, registers the write strobe, address and data into the RAM, and provides a registered read path with write-to-read bypass. It sits between the requesting datapath and the instantiated dual-port LUT RAM array, which it drives directly. An optional post-reset clear sequencer zeroes the array.

## Interface
- WIDTH, 8, data bits; one `RAM*X1D` per bit.
- ABITS, 6, address bits; only 6 or 7 are legal.
- CLK1  in  1  single clock; the RAM's WCLK is tied to this clock, positive edge.
- RST_N  in  1  reset, synchronous, active-low.
- A_VALID / B_VALID  in  1  requester write request.
- A_READY / B_READY  out  1  grant; a transfer occurs when VALID and READY are both high at a rising edge.
- A_ADDR / B_ADDR  in  ABITS  write address.
- A_DATA / B_DATA  in  WIDTH  write data.
- RD_ADDR  in  ABITS  read address, sampled every cycle.
- RD_DATA  out  WIDTH  registered read data.
- RAM_WE  out  1  to RAM `WE`, registered.
- RAM_WA  out  ABITS  to RAM `A`, registered.
- RAM_D  out  WIDTH  to RAM `D` per bit, registered.
- RAM_DPRA  out  ABITS  to RAM `DPRA`; combinational copy of RD_ADDR.
- RAM_DPO  in  WIDTH  from RAM `DPO`.
- INIT_DONE  out  1  high once the array is usable.

## Operation
- **States**
  - INIT: active only with the clear macro.
  - RUN: normal arbitration.
- **Arbitration (RUN only)**
  - READY is combinational from the VALIDs and the last-grant pointer `lg`.
  - Only one requester is valid: that requester is granted.
  - Both are valid: the requester other than `lg` is granted.
  - At most one READY is high in any cycle.
  - Both READYs are low in INIT.
- **Last-grant pointer**
  - Reset value is B, so A wins the first tie.
  - `lg` updates only on a completed transfer.
  - A VALID held high without a transfer does not move `lg`.
- **Accepted transfer at edge T**
  - At that edge, RAM_WE←1, RAM_WA←addr and RAM_D←data of the winner.
  - With no transfer, RAM_WE←0; RAM_WA and RAM_D hold their values.
- **Requester rules**
  - A requester must hold its ADDR and DATA stable while VALID is high and READY is low.
  - The bench checks this.
- **Read path**
  - RAM_DPRA=RD_ADDR.
  - At each edge, RD_DATA←RAM_DPO.
  - Bypass: if RAM_WE=1 and RAM_WA==RD_ADDR at that edge, RD_DATA←RAM_D instead. This is the value being written at the same edge.
- **Same-address writes**
  - Back-to-back writes to the same address from A and B are legal.
  - The last accepted write wins.
- **Reset values (RST_N low at an edge)**
  - RAM_WE=0, RAM_WA=0, RAM_D=0, RD_DATA=0, `lg`=B.
  - Any pending write is discarded, so RAM_WE is low in the cycle after the reset edge.
- **Reset during INIT**
  - Reset restarts the clear sequence from address 0.

## Timing
- **Write acceptance latency:** 0 cycles; READY follows VALID combinationally.
- **Write commit:** RAM_WE is high for the cycle after acceptance edge T, and the RAM content changes at edge T+1.
- **Read latency:** 1 cycle from RD_ADDR to RD_DATA.
- **Read-after-write:** a read sampled at edge T+1 to an address accepted at T returns the new data, through the bypass.
- **Throughput:** 1 write per cycle aggregate.
- **Fairness:** under continuous contention, A and B alternate every cycle.

## Configuration
- **DRAM_ARB_CLEAR_EN defined**
  - After reset, the block enters INIT and INIT_DONE=0.
  - The clear counter drives RAM_WE=1, RAM_D=0 and RAM_WA=0..2^ABITS−1, one address per cycle.
  - After the last address is issued, the block moves to RUN and INIT_DONE rises.
  - INIT_DONE is first high 2^ABITS+1 cycles after reset deassertion.
  - Reads during INIT are permitted and return whatever is in the array, with the bypass still applied.
- **DRAM_ARB_CLEAR_EN undefined**
  - There is no INIT state and no clear counter.
  - The block enters RUN directly; INIT_DONE resets to 1 and stays 1.
  - The array holds its INIT parameter contents.

## Test plan
- **Single write:** macro off, A writes addr 5 data 0x3C → A_READY=1 same cycle; RAM_WE=1, RAM_WA=5, RAM_D=0x3C next cycle; RD_ADDR=5 two cycles later returns RD_DATA=0x3C.
- **Contention:** A and B both valid for 6 cycles, A to addr 1 data 0x11 and B to addr 2 data 0x22 → grants A,B,A,B,A,B.
- **Held request:** B held valid while A is idle → grants B every cycle.
- **Bypass:** write 0xAA to addr 9 while RD_ADDR=9 in the commit cycle → RD_DATA=0xAA at the next edge, not the old contents.
- **Clear sequence:** macro on, ABITS=6, WIDTH=8, array preloaded non-zero → READY low and INIT_DONE=0 for 64 cycles, RAM_WA sweeps 0..63 with RAM_D=0, INIT_DONE=1 on cycle 65; a subsequent read of addr 63 returns 0x00.
- **Reset mid-operation:** assert RST_N low in the cycle after an accepted write, and at clear address 30 with the macro on → RAM_WE=0 and RD_DATA=0 after the reset edge; the clear restarts at addr 0.

Source files
------------

// File: rtl/xilinx_dram_wr_arbiter.sv
// xilinx_dram_wr_arbiter
// ----------------------
// This block is a round-robin write-port arbiter and read sequencer for a
// WIDTH x 2^ABITS distributed RAM. The RAM is built from one RAM64X1D
// (ABITS=6) or RAM128X1D (ABITS=7) per data bit. Only ABITS values of 6 and 7
// are meaningful.
//
// The block shares the RAM's single write port between requesters A and B,
// which use a valid/ready handshake. It registers the write strobe, address
// and data into the RAM. It also provides a registered read path with a
// write-to-read bypass.
//
// Optional feature: define DRAM_ARB_CLEAR_EN to zero the whole array after
// every reset before any requester is granted. The default build has no clear
// sequence, and INIT_DONE is tied high.
//
// Ports
//   CLK1                 single clock; the RAM's WCLK is tied to it (posedge)
//   RST_N                synchronous, active-low reset
//   A_VALID / B_VALID    write requests
//   A_READY / B_READY    grants (combinational); VALID&READY at an edge = transfer
//   A_ADDR / B_ADDR      write addresses
//   A_DATA / B_DATA      write data
//   RD_ADDR              read address, sampled every cycle
//   RD_DATA              registered read data (1-cycle latency)
//   RAM_WE/RAM_WA/RAM_D  registered write strobe/address/data to the RAM
//   RAM_DPRA             RAM read address (combinational copy of RD_ADDR)
//   RAM_DPO              RAM read data
//   INIT_DONE            high once the array is usable
module xilinx_dram_wr_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ABITS = 6
) (
  input  logic             CLK1,
  input  logic             RST_N,
  input  logic             A_VALID,
  output logic             A_READY,
  input  logic [ABITS-1:0] A_ADDR,
  input  logic [WIDTH-1:0] A_DATA,
  input  logic             B_VALID,
  output logic             B_READY,
  input  logic [ABITS-1:0] B_ADDR,
  input  logic [WIDTH-1:0] B_DATA,
  input  logic [ABITS-1:0] RD_ADDR,
  output logic [WIDTH-1:0] RD_DATA,
  output logic             RAM_WE,
  output logic [ABITS-1:0] RAM_WA,
  output logic [WIDTH-1:0] RAM_D,
  output logic [ABITS-1:0] RAM_DPRA,
  input  logic [WIDTH-1:0] RAM_DPO,
  output logic             INIT_DONE
);

  typedef enum logic { LG_A = 1'b0, LG_B = 1'b1 } last_grant_e;

  last_grant_e      lg_q, lg_d;
  logic             we_q, we_d;
  logic [ABITS-1:0] wa_q, wa_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] rd_q, rd_d;
  logic             run;

`ifdef DRAM_ARB_CLEAR_EN
  typedef enum logic { ST_INIT = 1'b0, ST_RUN = 1'b1 } state_e;

  localparam logic [ABITS-1:0] CLR_ONE = ABITS'(1);

  state_e           state_q, state_d;
  logic [ABITS-1:0] clr_q, clr_d;

  always_ff @(posedge CLK1) begin
    if (!RST_N) begin
      state_q <= ST_INIT;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  assign run = (state_q == ST_RUN);
`else
  assign run = 1'b1;
`endif

  // Grants are gated by RST_N so that nothing is accepted on a reset edge.
  always_comb begin
    A_READY = RST_N && run && A_VALID && (!B_VALID || (lg_q == LG_B));
    B_READY = RST_N && run && B_VALID && (!A_VALID || (lg_q == LG_A));
  end

  always_comb begin
    lg_d = lg_q;
    we_d = 1'b0;
    wa_d = wa_q;
    d_d  = d_q;
    // The RAM's DPO still shows the old word while a write to the same
    // address is committing, so forward the word being written instead.
    rd_d = (we_q && (wa_q == RD_ADDR)) ? d_q : RAM_DPO;
`ifdef DRAM_ARB_CLEAR_EN
    state_d = state_q;
    clr_d   = clr_q;
    if (state_q == ST_INIT) begin
      we_d  = 1'b1;
      wa_d  = clr_q;
      d_d   = '0;
      clr_d = clr_q + CLR_ONE;
      if (clr_q == '1) begin
        state_d = ST_RUN;
      end
    end else
`endif
    if (A_READY) begin
      we_d = 1'b1;
      wa_d = A_ADDR;
      d_d  = A_DATA;
      lg_d = LG_A;
    end else if (B_READY) begin
      we_d = 1'b1;
      wa_d = B_ADDR;
      d_d  = B_DATA;
      lg_d = LG_B;
    end
  end

  always_ff @(posedge CLK1) begin
    if (!RST_N) begin
      lg_q <= LG_B;
      we_q <= 1'b0;
      wa_q <= '0;
      d_q  <= '0;
      rd_q <= '0;
    end else begin
      lg_q <= lg_d;
      we_q <= we_d;
      wa_q <= wa_d;
      d_q  <= d_d;
      rd_q <= rd_d;
    end
  end

  assign RAM_WE    = we_q;
  assign RAM_WA    = wa_q;
  assign RAM_D     = d_q;
  assign RAM_DPRA  = RD_ADDR;
  assign RD_DATA   = rd_q;
  assign INIT_DONE = run;

endmodule

// File: tb/tb_xilinx_dram_wr_arbiter.sv
// Testbench for xilinx_dram_wr_arbiter (WIDTH=8, ABITS=6).
//
// A behavioural RAM stands in for the LUT RAM array. The reference model
// tracks the following:
//   - a shadow of the array contents, holding the latest accepted write per
//     address;
//   - the expected grant for each cycle;
//   - the expected registered outputs.
// Define DRAM_ARB_CLEAR_EN for both files to exercise the clear sequence.
module tb_xilinx_dram_wr_arbiter;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned ABITS = 6;
  localparam int unsigned DEPTH = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, a_valid, b_valid;
  logic [ABITS-1:0] a_addr, b_addr, rd_addr;
  logic [WIDTH-1:0] a_data, b_data;
  logic             a_ready, b_ready, ram_we, init_done;
  logic [ABITS-1:0] ram_wa, ram_dpra;
  logic [WIDTH-1:0] ram_d, ram_dpo, rd_data;

  xilinx_dram_wr_arbiter #(.WIDTH(WIDTH), .ABITS(ABITS)) dut (
    .CLK1(clk), .RST_N(rst_n),
    .A_VALID(a_valid), .A_READY(a_ready), .A_ADDR(a_addr), .A_DATA(a_data),
    .B_VALID(b_valid), .B_READY(b_ready), .B_ADDR(b_addr), .B_DATA(b_data),
    .RD_ADDR(rd_addr), .RD_DATA(rd_data),
    .RAM_WE(ram_we), .RAM_WA(ram_wa), .RAM_D(ram_d),
    .RAM_DPRA(ram_dpra), .RAM_DPO(ram_dpo), .INIT_DONE(init_done)
  );

  // Distributed RAM: synchronous write, asynchronous read, non-zero preload.
  logic [WIDTH-1:0] ram [DEPTH];
  assign ram_dpo = ram[ram_dpra];
  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = 8'(i * 7 + 1) | 8'h80;
    forever begin
      @(posedge clk);
      if (ram_we) ram[ram_wa] <= ram_d;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] shadow [DEPTH];
  int               m_lg;      // last granted requester: 0 = A, 1 = B
  bit               m_init;
  logic [ABITS-1:0] m_clr;
  logic             e_we;
  logic [ABITS-1:0] e_wa;
  logic [WIDTH-1:0] e_d, e_rd;
  bit               a_took, b_took;
  bit               chk_en = 1'b0;
  int               g;

  // Returns 0 for no grant, 1 for grant to A, 2 for grant to B.
  function automatic int exp_grant();
    if (!rst_n || m_init) return 0;
    if (a_valid && b_valid) return (m_lg == 1) ? 1 : 2;
    if (a_valid) return 1;
    if (b_valid) return 2;
    return 0;
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) shadow[i] = 8'(i * 7 + 1) | 8'h80;
    forever begin
      @(posedge clk);
      a_took = 1'b0;
      b_took = 1'b0;
      if (!rst_n) begin
        e_we = 1'b0; e_wa = '0; e_d = '0; e_rd = '0; m_lg = 1; m_clr = '0;
`ifdef DRAM_ARB_CLEAR_EN
        m_init = 1'b1;
`else
        m_init = 1'b0;
`endif
      end else begin
        // Read result: every write issued before this edge is visible.
        e_rd = shadow[rd_addr];
        if (m_init) begin
          shadow[m_clr] = '0;
          e_we = 1'b1; e_wa = m_clr; e_d = '0;
          if (m_clr == 6'(DEPTH - 1)) m_init = 1'b0;
          m_clr = m_clr + 6'd1;
        end else begin
          g = exp_grant();
          if (g == 1) begin
            shadow[a_addr] = a_data; e_we = 1'b1; e_wa = a_addr; e_d = a_data;
            m_lg = 0; a_took = 1'b1;
          end else if (g == 2) begin
            shadow[b_addr] = b_data; e_we = 1'b1; e_wa = b_addr; e_d = b_data;
            m_lg = 1; b_took = 1'b1;
          end else begin
            e_we = 1'b0;
          end
        end
      end
    end
  end

  // Compare process: every negedge once reset has been applied.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("a_ready", 32'(a_ready), 32'(exp_grant() == 1));
      chk("b_ready", 32'(b_ready), 32'(exp_grant() == 2));
      chk("ram_we", 32'(ram_we), 32'(e_we));
      chk("ram_wa", 32'(ram_wa), 32'(e_wa));
      chk("ram_d", 32'(ram_d), 32'(e_d));
      chk("rd_data", 32'(rd_data), 32'(e_rd));
      chk("init_done", 32'(init_done), 32'(!m_init));
      chk("ram_dpra", 32'(ram_dpra), 32'(rd_addr));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  task automatic bring_up();
    a_valid = 1'b0; b_valid = 1'b0; rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
`ifdef DRAM_ARB_CLEAR_EN
    repeat (DEPTH) step();
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0; rd_addr = 6'd63;
    step(); step();
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Post-reset state, cycle 1.
    look();
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_rd", 32'(rd_data), 32'd0);
    chk("rst_a_ready", 32'(a_ready), 32'd0);
`ifdef DRAM_ARB_CLEAR_EN
    chk("rst_init_done", 32'(init_done), 32'd0);
    for (int k = 2; k <= int'(DEPTH); k++) begin
      step(); look();
      chk("clr_init_done", 32'(init_done), 32'd0);
      chk("clr_we", 32'(ram_we), 32'd1);
      chk("clr_wa", 32'(ram_wa), 32'(k - 2));
      chk("clr_d", 32'(ram_d), 32'd0);
    end
    step(); look();
    chk("clr_done65", 32'(init_done), 32'd1);
    chk("clr_last_wa", 32'(ram_wa), 32'd63);
    step(); look();
    chk("clr_rd63", 32'(rd_data), 32'd0);
`else
    chk("rst_init_done", 32'(init_done), 32'd1);
`endif

    // Single write from A.
    step();
    a_valid = 1'b1; a_addr = 6'd5; a_data = 8'h3C; rd_addr = 6'd5;
    look();
    chk("single_a_ready", 32'(a_ready), 32'd1);
    chk("single_b_ready", 32'(b_ready), 32'd0);
    step();
    a_valid = 1'b0;
    look();
    chk("single_we", 32'(ram_we), 32'd1);
    chk("single_wa", 32'(ram_wa), 32'd5);
    chk("single_d", 32'(ram_d), 32'h3C);
    step(); look();
    chk("single_rd", 32'(rd_data), 32'h3C);

    // Contention from a fresh reset: A wins first, then strict alternation.
    bring_up();
    step();
    a_valid = 1'b1; a_addr = 6'd1; a_data = 8'h11;
    b_valid = 1'b1; b_addr = 6'd2; b_data = 8'h22;
    for (int i = 0; i < 6; i++) begin
      look();
      chk("cont_a_ready", 32'(a_ready), 32'(i % 2 == 0));
      chk("cont_b_ready", 32'(b_ready), 32'(i % 2 == 1));
      step();
    end
    a_valid = 1'b0;

    // Held request: B alone is granted every cycle.
    b_addr = 6'd3; b_data = 8'h33;
    for (int i = 0; i < 3; i++) begin
      look();
      chk("held_b_ready", 32'(b_ready), 32'd1);
      chk("held_a_ready", 32'(a_ready), 32'd0);
      step();
    end
    b_valid = 1'b0;

    // Bypass: old contents 0x55, then 0xAA is read back during its commit cycle.
    a_valid = 1'b1; a_addr = 6'd9; a_data = 8'h55; rd_addr = 6'd0;
    step();
    a_valid = 1'b0;
    step(); step();
    a_valid = 1'b1; a_data = 8'hAA;
    step();
    a_valid = 1'b0; rd_addr = 6'd9;
    look();
    chk("byp_we", 32'(ram_we), 32'd1);
    chk("byp_wa", 32'(ram_wa), 32'd9);
    step(); look();
    chk("byp_rd", 32'(rd_data), 32'hAA);

    // Reset in the cycle after an accepted write.
    step();
    a_valid = 1'b1; a_addr = 6'd7; a_data = 8'h77; rd_addr = 6'd7;
    step();
    a_valid = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    look();
    chk("midrst_we", 32'(ram_we), 32'd0);
    chk("midrst_rd", 32'(rd_data), 32'd0);
`ifdef DRAM_ARB_CLEAR_EN
    step(); look();
    chk("midrst_clr_wa", 32'(ram_wa), 32'd0);
    chk("midrst_clr_we", 32'(ram_we), 32'd1);
    // Reset again while clear address 30 is on RAM_WA.
    repeat (29) step();
    step();
    rst_n = 1'b0;
    look();
    chk("clr30_wa", 32'(ram_wa), 32'd30);
    step();
    rst_n = 1'b1;
    look();
    chk("clr30_rst_we", 32'(ram_we), 32'd0);
    chk("clr30_init_done", 32'(init_done), 32'd0);
    step(); look();
    chk("clr30_restart_wa", 32'(ram_wa), 32'd0);
    repeat (DEPTH) step();
`endif

    // Randomized traffic with occasional resets; requesters hold stalled requests.
    for (int c = 0; c < 3000; c++) begin
      step();
      rst_n = ($urandom_range(0, 399) != 0);
      if (!(a_valid && !a_took)) begin
        a_valid = ($urandom_range(0, 2) != 0);
        a_addr  = 6'($urandom_range(0, 15));
        a_data  = 8'($urandom);
      end
      if (!(b_valid && !b_took)) begin
        b_valid = ($urandom_range(0, 2) != 0);
        b_addr  = 6'($urandom_range(0, 15));
        b_data  = 8'($urandom);
      end
      rd_addr = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                            : 6'($urandom_range(0, 15));
    end
    step(); look();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
